// File: rtl/handshake_tx.sv
// handshake_tx: sending side of a 4-phase req/ack handshake that moves one
// data word per transfer into a foreign clock domain. The returning
// acknowledge is synchronised locally; each handshake phase is guarded by a
// saturating timeout counter so a dead receiver cannot hang the sender.
module handshake_tx #(
  parameter int DATA_W         = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              xfer_req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              xfer_ack,
  output logic              done,
  output logic              timeout
);

  // A zero timeout disables the counter; keep a 1-bit stub so widths stay legal.
  localparam bit             TO_EN   = (TIMEOUT_CYCLES > 0);
  localparam int             CNT_W   = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_ABORT   = 2'd3;

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   ack_s;

  logic [1:0]        state_d, state_q;
  logic              req_d, req_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              done_d, done_q;
  logic              timeout_d, timeout_q;

  logic              cnt_hit;
  logic [CNT_W-1:0]  cnt_inc;

  // Synchroniser chain: stage 0 samples the raw ack, later stages shift it on.
  assign sync_d[0] = xfer_ack;
  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  // Only the last synchroniser stage is ever looked at by the control logic.
  assign ack_s = sync_q[SYNC_STAGES-1];

  // Phase timer helpers: hit when the phase has lasted TIMEOUT_CYCLES, saturating increment.
  always_comb begin
    cnt_hit = TO_EN && (cnt_q == CNT_MAX);
    cnt_inc = '0;
    if (TO_EN) begin
      cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Handshake state machine: accept, wait ack high, wait ack low, or recover from a stall.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A stale ack from an aborted transfer blocks new work until it clears.
        if (in_valid && !ack_s) begin
          data_d  = in_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (cnt_hit) begin
          timeout_d = 1'b1;
          req_d     = 1'b0;
          cnt_d     = '0;
          state_d   = S_ABORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ABORT: begin
        // Request already dropped; give a late ack a chance to fall quietly.
        if (!ack_s) begin
          state_d = S_IDLE;
        end else if (cnt_hit) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, data and pulse registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      state_q   <= S_IDLE;
      req_q     <= 1'b0;
      data_q    <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      req_q     <= req_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !ack_s;
  assign xfer_req  = req_q;
  assign xfer_data = data_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_handshake_tx.sv
// Testbench for handshake_tx: a driver issues words, a responder model plays
// the remote receiver (normal echo, never ack, ack stuck high), and a monitor
// checks every DUT event against a queue of expected transactions.
module tb_handshake_tx;

  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 16;

  localparam int M_NORMAL = 0;
  localparam int M_NOACK  = 1;
  localparam int M_STUCK  = 2;

  typedef struct {
    logic [7:0] data;
    int         mode;
  } exp_t;

  typedef struct {
    int mode;
    int d1;
    int d2;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          xfer_req;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack;
  logic          done;
  logic          timeout;

  logic resp_ack  = 1'b0;
  logic force_ack = 1'b0;
  assign xfer_ack = resp_ack | force_ack;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  exp_t  mon_e;

  int         ack_rise_cyc = 0;
  int         ack_fall_cyc = 0;
  int         rise_cyc = 0;
  int         fall_cyc = 0;
  logic [7:0] held = '0;
  logic       prev_req = 1'b0;
  bit         stuck_to_flag = 1'b0;
  bit         ready_next = 1'b0;
  bit         resp_busy = 1'b0;
  int         n_done = 0, n_to = 0, n_done_exp = 0, n_to_exp = 0;

  handshake_tx #(
    .DATA_W(DW),
    .SYNC_STAGES(SS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .xfer_req(xfer_req),
    .xfer_data(xfer_data),
    .xfer_ack(xfer_ack),
    .done(done),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Monitor: compare every request edge and completion pulse with the scoreboard.
  always @(negedge clk) begin
    if (ready_next) begin
      ready_next = 1'b0;
      chk("abort_ready_next", {31'd0, in_ready}, 32'd1);
    end
    if (xfer_req && !prev_req) begin
      rise_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_accept", exp_q.size(), 32'd1);
      else                   chk("accept_data", {24'd0, xfer_data}, {24'd0, exp_q[0].data});
      held = xfer_data;
    end else if (xfer_req && prev_req) begin
      chk("data_hold", {24'd0, xfer_data}, {24'd0, held});
    end
    if (xfer_req) chk("busy_ready", {31'd0, in_ready}, 32'd0);
    if (!xfer_req && prev_req) begin
      fall_cyc = cyc;
      if (exp_q.size() > 0 && exp_q[0].mode != M_NOACK)
        chk("req_fall_lat", cyc, ack_rise_cyc + SS + 1);
    end
    if (done || timeout) begin
      chk("pulse_exclusive", {31'd0, done & timeout}, 32'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", exp_q.size(), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        if (done) begin
          n_done++;
          chk("done_mode", mon_e.mode, M_NORMAL);
          chk("done_lat", cyc, ack_fall_cyc + SS + 1);
          chk("done_data", {24'd0, xfer_data}, {24'd0, mon_e.data});
          chk("done_ready", {31'd0, in_ready}, 32'd1);
          $display("xfer data=%02h outcome=done cycle=%0d", mon_e.data, cyc);
        end else begin
          n_to++;
          if (mon_e.mode == M_NOACK) begin
            chk("req_timeout_lat", cyc, rise_cyc + TO + 1);
            chk("req_timeout_req", {31'd0, xfer_req}, 32'd0);
            chk("req_timeout_ready", {31'd0, in_ready}, 32'd0);
            ready_next = 1'b1;
          end else if (mon_e.mode == M_STUCK) begin
            chk("rel_timeout_lat", cyc, fall_cyc + TO + 1);
            stuck_to_flag = 1'b1;
          end else begin
            chk("timeout_mode", mon_e.mode, M_NOACK);
          end
          chk("timeout_data", {24'd0, xfer_data}, {24'd0, mon_e.data});
          $display("xfer data=%02h outcome=timeout cycle=%0d", mon_e.data, cyc);
        end
      end
    end
    prev_req = xfer_req;
  end

  // Responder: plays the remote receiver for each accepted word.
  initial begin : responder
    resp_t r;
    int    n;
    forever begin
      @(posedge clk); #1;
      if (!rst && xfer_req && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        resp_busy = 1'b1;
        if (r.mode == M_NOACK) begin
          n = 0;
          while (xfer_req && n < 100) begin @(posedge clk); #1; n++; end
          chk("noack_req_drop", {31'd0, xfer_req}, 32'd0);
        end else begin
          repeat (r.d1) begin @(posedge clk); #1; end
          resp_ack = 1'b1;
          ack_rise_cyc = cyc;
          if (r.mode == M_NORMAL) begin
            n = 0;
            while (xfer_req && n < 100) begin @(posedge clk); #1; n++; end
            chk("resp_req_low", {31'd0, xfer_req}, 32'd0);
            repeat (r.d2) begin @(posedge clk); #1; end
            resp_ack = 1'b0;
            ack_fall_cyc = cyc;
          end else begin
            n = 0;
            while (!stuck_to_flag && n < 200) begin @(posedge clk); #1; n++; end
            chk("stuck_timeout_seen", {31'd0, stuck_to_flag}, 32'd1);
            stuck_to_flag = 1'b0;
            chk("stale_ack_ready", {31'd0, in_ready}, 32'd0);
            repeat (r.d2) begin @(posedge clk); #1; end
            resp_ack = 1'b0;
            ack_fall_cyc = cyc;
            repeat (SS - 1) begin @(posedge clk); #1; end
            chk("stale_ack_blocked", {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            chk("stale_ack_cleared", {31'd0, in_ready}, 32'd1);
          end
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Present one word until accepted; optionally poke a busy-time word or keep valid high.
  task automatic send(input logic [7:0] d, input int mode, input int d1, input int d2,
                      input bit b2b, input bit poke);
    resp_t r;
    exp_t  e;
    bit    acc;
    int    n;
    r.mode = mode; r.d1 = d1; r.d2 = d2;
    resp_q.push_back(r);
    in_valid = 1'b1;
    in_data  = d;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", {31'd0, acc}, 32'd1);
    if (acc) begin
      e.data = d; e.mode = mode;
      exp_q.push_back(e);
      if (mode == M_NORMAL) n_done_exp++;
      else                  n_to_exp++;
    end
    if (poke) begin
      in_data = 8'h77;
      @(posedge clk); #1;
    end
    if (!b2b) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int gap);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || resp_q.size() != 0 || resp_busy) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", exp_q.size(), 32'd0);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Main stimulus: reset checks, directed transfers, then randomized traffic.
  initial begin : main
    int f;
    rst = 1'b1;
    force_ack = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req", {31'd0, xfer_req}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_timeout", {31'd0, timeout}, 32'd0);
    chk("reset_data", {24'd0, xfer_data}, 32'd0);
    chk("reset_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (SS) @(posedge clk);
    @(negedge clk);
    chk("stale_ack_after_reset", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    force_ack = 1'b0;
    f = cyc;
    repeat (SS - 1) @(posedge clk);
    @(negedge clk);
    chk("ready_before_clear", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("ready_after_clear", {31'd0, in_ready}, 32'd1);
    chk("ready_clear_lat", cyc, f + SS);
    @(posedge clk); #1;

    // Single transfer, receiver echoes after 3 cycles.
    send(8'hA5, M_NORMAL, 3, 3, 1'b0, 1'b0);
    wait_idle(2);
    // Back-to-back with valid held high.
    send(8'h01, M_NORMAL, 1, 1, 1'b1, 1'b0);
    send(8'h02, M_NORMAL, 1, 1, 1'b1, 1'b0);
    send(8'h03, M_NORMAL, 1, 1, 1'b0, 1'b0);
    wait_idle(2);
    // Busy poke during REQ must be ignored.
    send(8'h10, M_NORMAL, 5, 2, 1'b0, 1'b1);
    wait_idle(2);
    // Receiver never acks.
    send(8'h20, M_NOACK, 0, 0, 1'b0, 1'b0);
    wait_idle(2);
    // Ack stuck high during release.
    send(8'h30, M_STUCK, 2, 3, 1'b0, 1'b0);
    wait_idle(2);

    // Reset in the middle of REQ.
    send(8'h5A, M_NOACK, 0, 0, 1'b0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req", {31'd0, xfer_req}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_timeout", {31'd0, timeout}, 32'd0);
    chk("midrst_data", {24'd0, xfer_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    n_to_exp--;
    repeat (2) begin @(posedge clk); #1; end
    send(8'h3C, M_NORMAL, 2, 2, 1'b0, 1'b0);
    wait_idle(2);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int  m;
      int  mode;
      bit  b2b;
      m = int'($urandom_range(0, 9));
      mode = (m < 6) ? M_NORMAL : ((m < 8) ? M_NOACK : M_STUCK);
      b2b = (i != 39) && ($urandom_range(0, 1) == 1);
      send(8'($urandom_range(0, 255)), mode, int'($urandom_range(0, 10)),
           int'($urandom_range(0, 10)), b2b, ($urandom_range(0, 3) == 0));
      if (!b2b) wait_idle(int'($urandom_range(0, 3)));
    end
    in_valid = 1'b0;
    wait_idle(3);
    chk("done_count", n_done, n_done_exp);
    chk("timeout_count", n_to, n_to_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
